// File: rtl/frame_stream_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// frame_stream_pkg: state encoding and framing constants for the streamer
// Rev 1.0
// ------------------------------------------------------------------
package frame_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR      = 3'd1,
    ST_DATA     = 3'd2,
    ST_CSUM     = 3'd3,
    ST_WAIT_LOW = 3'd4
  } state_t;

  localparam int unsigned HDR_LEN  = 8;
  localparam int unsigned CSUM_LEN = 4;
  localparam logic [31:0] DEFAULT_MAGIC = 32'h55AA_F00F;

  // Number of 32-bit serializer loads needed to emit a fixed-length section.
  function automatic logic [1:0] words_of(input int unsigned nbytes);
    return 2'(nbytes / 4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_byte_streamer_byte_serializer.sv
`default_nettype none
// ------------------------------------------------------------------
// byte_serializer: one-word buffer emitting 4 bytes LSB-first over valid/ready
// Rev 1.0
// ------------------------------------------------------------------
module byte_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_word,
  input  logic        i_load,
  output logic        o_load_rdy,
  output logic        o_full,
  output logic        o_last,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy
);

  logic [23:0] r_upper;
  logic [1:0]  r_idx;
  logic [7:0]  r_tx_data;
  logic        r_tx_vld;
  logic        w_xfer;
  logic        w_last;
  logic        w_load;
  logic [7:0]  w_next_byte;

  assign w_xfer     = r_tx_vld & i_tx_rdy;
  assign w_last     = w_xfer & (r_idx == 2'd3);
  // A new word may overlap the final byte transfer so back-to-back words stream gap-free.
  assign o_load_rdy = ~r_tx_vld | w_last;
  assign w_load     = i_load & o_load_rdy;

  always_comb begin
    w_next_byte = r_upper[23:16];
    case (r_idx)
      2'd0:    w_next_byte = r_upper[7:0];
      2'd1:    w_next_byte = r_upper[15:8];
      default: w_next_byte = r_upper[23:16];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_upper   <= 24'd0;
      r_idx     <= 2'd0;
      r_tx_data <= 8'd0;
      r_tx_vld  <= 1'b0;
    end else if (w_load) begin
      r_upper   <= i_word[31:8];
      r_idx     <= 2'd0;
      r_tx_data <= i_word[7:0];
      r_tx_vld  <= 1'b1;
    end else if (w_xfer) begin
      if (r_idx == 2'd3) begin
        r_tx_vld <= 1'b0;
      end else begin
        r_idx     <= r_idx + 2'd1;
        r_tx_data <= w_next_byte;
      end
    end
  end

  assign o_full    = r_tx_vld;
  assign o_last    = w_last;
  assign o_tx_data = r_tx_data;
  assign o_tx_vld  = r_tx_vld;

endmodule
`default_nettype wire

// File: rtl/frame_byte_streamer.sv
`default_nettype none
// ------------------------------------------------------------------
// frame_byte_streamer: wraps a buffered word frame in header/checksum onto a byte link
// Rev 1.0
// ------------------------------------------------------------------
module frame_byte_streamer
  import frame_stream_pkg::*;
#(
  parameter logic [31:0] HDR_MAGIC = DEFAULT_MAGIC,
  parameter bit          CSUM_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_ready,
  input  logic [15:0] i_frame_size,
  input  logic [31:0] i_data,
  input  logic        i_vld,
  output logic        o_rdy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_vld,
  input  logic        i_tx_rdy,
  output logic        o_busy,
  output logic [15:0] o_seq,
  output logic [15:0] o_drop_cnt
);

  localparam logic [1:0] c_HDR_WORDS  = words_of(HDR_LEN);
  localparam logic [1:0] c_CSUM_WORDS = words_of(CSUM_LEN);

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_after_body;
  logic        r_fr_prev;
  logic [15:0] r_size;
  logic [15:0] r_taken;
  logic [15:0] r_seq;
  logic [15:0] r_drop_cnt;
  logic [31:0] r_csum;
  logic [1:0]  r_sec_cnt;

  logic        w_rise;
  logic        w_start;
  logic        w_rdy;
  logic        w_ld_vld;
  logic        w_ld_rdy;
  logic [31:0] w_ld_word;
  logic        w_ser_full;
  logic        w_ser_last;

  assign w_rise       = i_frame_ready & ~r_fr_prev;
  assign w_start      = w_rise & (r_state == ST_IDLE);
  assign w_after_body = CSUM_EN ? ST_CSUM : ST_WAIT_LOW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The serializer input word is muxed per section; r_sec_cnt counts words loaded in it.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_vld    = 1'b0;
    w_ld_word   = i_data;
    w_rdy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        w_ld_word = (r_sec_cnt == 2'd0) ? HDR_MAGIC : {r_seq, r_size};
        w_ld_vld  = (r_sec_cnt < c_HDR_WORDS);
        if (w_ser_last && (r_sec_cnt == c_HDR_WORDS))
          w_state_nxt = (r_size == 16'd0) ? w_after_body : ST_DATA;
      end
      ST_DATA: begin
        w_rdy    = ~w_ser_full & (r_taken < r_size);
        w_ld_vld = i_vld & w_rdy;
        if (w_ser_last && (r_taken == r_size)) w_state_nxt = w_after_body;
      end
      ST_CSUM: begin
        w_ld_word = r_csum;
        w_ld_vld  = (r_sec_cnt < c_CSUM_WORDS);
        if (w_ser_last && (r_sec_cnt == c_CSUM_WORDS)) w_state_nxt = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!i_frame_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fr_prev  <= 1'b0;
      r_size     <= 16'd0;
      r_taken    <= 16'd0;
      r_seq      <= 16'd0;
      r_drop_cnt <= 16'd0;
      r_csum     <= 32'd0;
      r_sec_cnt  <= 2'd0;
    end else begin
      r_fr_prev <= i_frame_ready;
      if (w_state_nxt != r_state) begin
        r_sec_cnt <= 2'd0;
      end else if (w_ld_vld && w_ld_rdy && (r_state != ST_DATA)) begin
        r_sec_cnt <= r_sec_cnt + 2'd1;
      end
      if (w_start) begin
        r_size  <= i_frame_size;
        r_seq   <= r_seq + 16'd1;
        r_csum  <= 32'd0;
        r_taken <= 16'd0;
      end else begin
        if (w_rise && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        if (i_vld && w_rdy) begin
          r_taken <= r_taken + 16'd1;
          r_csum  <= r_csum + i_data;
        end
      end
    end
  end

  byte_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_word     (w_ld_word),
    .i_load     (w_ld_vld),
    .o_load_rdy (w_ld_rdy),
    .o_full     (w_ser_full),
    .o_last     (w_ser_last),
    .o_tx_data  (o_tx_data),
    .o_tx_vld   (o_tx_vld),
    .i_tx_rdy   (i_tx_rdy)
  );

  assign o_rdy      = w_rdy;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_seq      = r_seq;
  assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire
